chaining_record_writer: RTL and testbench

Owns one vector-chaining record and builds it up as an instruction's element writes land in the VRF. It is the producer side of the chaining hazard check. Each lane-side read checker consumes the `record_*` outputs and compares them against its pending read. The record is allocated at instruction issue, is marked element by element as write-backs complete, and is freed when the instruction retires.

---
 rtl/chaining_record_writer.sv | 139 +++++++++++++
 tb/tb_chaining_record_writer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/chaining_record_writer.sv
// Producer side of the vector-chaining hazard check: one record that is allocated at
// issue, marked element by element as write-backs land, and freed at retire.
module chaining_record_writer #(
    parameter int OFFSET_BITS = 9,
    parameter int INST_BITS   = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          alloc_valid,
    output logic                          alloc_ready,
    input  logic                          alloc_vd_valid,
    input  logic [4:0]                    alloc_vd,
    input  logic [INST_BITS-1:0]          alloc_instIndex,
    input  logic [OFFSET_BITS+3:0]        alloc_elemCount,
    input  logic                          write_valid,
    input  logic [4:0]                    write_vs,
    input  logic [OFFSET_BITS-1:0]        write_offset,
    input  logic [INST_BITS-1:0]          write_instIndex,
    input  logic                          retire_valid,
    input  logic [INST_BITS-1:0]          retire_instIndex,
    output logic                          recordValid,
    output logic                          record_bits_vd_valid,
    output logic [4:0]                    record_bits_vd_bits,
    output logic [INST_BITS-1:0]          record_bits_instIndex,
    output logic [(8<<OFFSET_BITS)-1:0]   record_bits_elementMask,
    output logic                          record_done,
    output logic                          write_error
);

    localparam int MASK_W = 8 << OFFSET_BITS;
    localparam int CNT_W  = OFFSET_BITS + 4;
    localparam int IDX_W  = OFFSET_BITS + 3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]           state_q, state_d;
    logic                 vd_valid_q, vd_valid_d;
    logic [4:0]           vd_q, vd_d;
    logic [INST_BITS-1:0] inst_q, inst_d;
    logic [CNT_W-1:0]     elem_count_q, elem_count_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [MASK_W-1:0]    mask_q, mask_d;
    logic                 write_error_q, write_error_d;

    logic                 record_live;
    logic                 retire_hit;
    logic                 alloc_fire;
    logic                 write_hit;
    logic [4:0]           rel;
    logic                 in_window;
    logic [IDX_W-1:0]     elem_idx;
    logic                 set_en;
    logic                 new_bit;
    logic                 cnt_sat;

    assign record_live = (state_q != ST_IDLE);
    assign retire_hit  = retire_valid & record_live & (retire_instIndex == inst_q);
    assign alloc_ready = (state_q == ST_IDLE) | retire_hit;
    assign alloc_fire  = alloc_valid & alloc_ready;

    // A write that races a retire hit (or the replacing allocation) belongs to a record
    // that is going away, so it is dropped without raising an error.
    assign write_hit = write_valid & record_live & vd_valid_q
                     & (write_instIndex == inst_q) & ~retire_hit;

    assign rel       = write_vs - vd_q;
    assign in_window = (rel[4:3] == 2'b00);
    assign elem_idx  = {rel[2:0], write_offset};
    assign set_en    = write_hit & in_window;
    assign new_bit   = set_en & ~mask_q[elem_idx];
    assign cnt_sat   = (cnt_q == CNT_W'(MASK_W));

    always_comb begin
        state_d       = state_q;
        vd_valid_d    = vd_valid_q;
        vd_d          = vd_q;
        inst_d        = inst_q;
        elem_count_d  = elem_count_q;
        cnt_d         = cnt_q;
        mask_d        = mask_q;
        write_error_d = write_hit & ~in_window;

        if (new_bit && !cnt_sat) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (set_en) begin
            mask_d[elem_idx] = 1'b1;
        end
        if (state_q == ST_ACTIVE && cnt_d >= elem_count_q) begin
            state_d = ST_DONE;
        end
        if (retire_hit) begin
            state_d = ST_IDLE;
        end
        if (alloc_fire) begin
            vd_valid_d   = alloc_vd_valid;
            vd_d         = alloc_vd;
            inst_d       = alloc_instIndex;
            elem_count_d = alloc_elemCount;
            cnt_d        = '0;
            mask_d       = '0;
            // A record with no vector destination has nothing to wait for.
            state_d      = alloc_vd_valid ? ST_ACTIVE : ST_DONE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            vd_valid_q    <= 1'b0;
            vd_q          <= '0;
            inst_q        <= '0;
            elem_count_q  <= '0;
            cnt_q         <= '0;
            mask_q        <= '0;
            write_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            vd_valid_q    <= vd_valid_d;
            vd_q          <= vd_d;
            inst_q        <= inst_d;
            elem_count_q  <= elem_count_d;
            cnt_q         <= cnt_d;
            mask_q        <= mask_d;
            write_error_q <= write_error_d;
        end
    end

    assign recordValid             = record_live;
    assign record_done             = (state_q == ST_DONE);
    assign record_bits_vd_valid    = vd_valid_q;
    assign record_bits_vd_bits     = vd_q;
    assign record_bits_instIndex   = inst_q;
    assign record_bits_elementMask = mask_q;
    assign write_error             = write_error_q;

endmodule

// File: tb/tb_chaining_record_writer.sv
// Randomised and directed bench for chaining_record_writer: a set-based record model
// predicts each cycle's outputs into a queue that an independent monitor drains.
module tb_chaining_record_writer;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          alloc_valid = 1'b0;
    logic          alloc_ready;
    logic          alloc_vd_valid = 1'b0;
    logic [4:0]    alloc_vd = '0;
    logic [2:0]    alloc_instIndex = '0;
    logic [12:0]   alloc_elemCount = '0;
    logic          write_valid = 1'b0;
    logic [4:0]    write_vs = '0;
    logic [8:0]    write_offset = '0;
    logic [2:0]    write_instIndex = '0;
    logic          retire_valid = 1'b0;
    logic [2:0]    retire_instIndex = '0;
    logic          recordValid;
    logic          record_bits_vd_valid;
    logic [4:0]    record_bits_vd_bits;
    logic [2:0]    record_bits_instIndex;
    logic [4095:0] record_bits_elementMask;
    logic          record_done;
    logic          write_error;

    chaining_record_writer dut (
        .clock                   (clock),
        .reset                   (reset),
        .alloc_valid             (alloc_valid),
        .alloc_ready             (alloc_ready),
        .alloc_vd_valid          (alloc_vd_valid),
        .alloc_vd                (alloc_vd),
        .alloc_instIndex         (alloc_instIndex),
        .alloc_elemCount         (alloc_elemCount),
        .write_valid             (write_valid),
        .write_vs                (write_vs),
        .write_offset            (write_offset),
        .write_instIndex         (write_instIndex),
        .retire_valid            (retire_valid),
        .retire_instIndex        (retire_instIndex),
        .recordValid             (recordValid),
        .record_bits_vd_valid    (record_bits_vd_valid),
        .record_bits_vd_bits     (record_bits_vd_bits),
        .record_bits_instIndex   (record_bits_instIndex),
        .record_bits_elementMask (record_bits_elementMask),
        .record_done             (record_done),
        .write_error             (write_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          ready;
        logic          live;
        logic          done;
        logic          vdv;
        logic [4:0]    vd;
        logic [2:0]    inst;
        logic          err;
        logic          chk_mask;
        logic [4095:0] mask;
    } snap_t;

    snap_t sb[$];
    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Reference record: a set of written elements plus the allocation fields.
    logic          m_live = 1'b0;
    logic          m_vdv  = 1'b0;
    logic [4:0]    m_vd   = '0;
    logic [2:0]    m_inst = '0;
    int            m_cnt  = 0;
    logic          m_err  = 1'b0;
    logic [4095:0] m_mask = '0;

    function automatic logic m_done();
        return m_live && (!m_vdv || ($countones(m_mask) >= m_cnt));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_mask(input logic [4095:0] act, input logic [4095:0] exp);
        int first;
        checks++;
        if (act !== exp) begin
            errors++;
            first = -1;
            for (int i = 0; i < 4096; i++) begin
                if (first < 0 && act[i] !== exp[i]) first = i;
            end
            $display("FAIL mask actual_ones=%0d required_ones=%0d first_diff_bit=%0d (t=%0t)",
                     $countones(act), $countones(exp), first, $time);
        end
    endtask

    // Monitor: outputs seen mid-cycle are compared with the prediction queued for that cycle.
    initial begin
        snap_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                txn++;
                chk("alloc_ready", 32'(alloc_ready), 32'(e.ready));
                chk("recordValid", 32'(recordValid), 32'(e.live));
                chk("record_done", 32'(record_done), 32'(e.done));
                chk("write_error", 32'(write_error), 32'(e.err));
                chk("vd_valid", 32'(record_bits_vd_valid), 32'(e.vdv));
                chk("vd_bits", 32'(record_bits_vd_bits), 32'(e.vd));
                chk("instIndex", 32'(record_bits_instIndex), 32'(e.inst));
                if (e.chk_mask) chk_mask(record_bits_elementMask, e.mask);
                $display("txn %0d live=%0b done=%0b err=%0b inst=%0d vd=%0d ones=%0d",
                         txn, recordValid, record_done, write_error,
                         record_bits_instIndex, record_bits_vd_bits,
                         $countones(record_bits_elementMask));
            end
        end
    end

    task automatic cyc(input logic av, input logic avdv, input logic [4:0] avd,
                       input logic [2:0] ai, input logic [12:0] ac,
                       input logic wv, input logic [4:0] wvs, input logic [8:0] wo,
                       input logic [2:0] wi, input logic rv, input logic [2:0] ri);
        logic  hit, rdy, acc, err_n;
        int    rel;
        snap_t s;
        @(posedge clock);
        #1;
        alloc_valid = av; alloc_vd_valid = avdv; alloc_vd = avd;
        alloc_instIndex = ai; alloc_elemCount = ac;
        write_valid = wv; write_vs = wvs; write_offset = wo; write_instIndex = wi;
        retire_valid = rv; retire_instIndex = ri;

        hit = m_live && rv && (ri == m_inst);
        rdy = !m_live || hit;
        s.ready = rdy; s.live = m_live; s.done = m_done(); s.vdv = m_vdv;
        s.vd = m_vd; s.inst = m_inst; s.err = m_err; s.chk_mask = m_live; s.mask = m_mask;
        sb.push_back(s);

        err_n = 1'b0;
        acc = m_live && m_vdv && wv && (wi == m_inst) && !hit;
        if (acc) begin
            rel = ((int'(wvs) - int'(m_vd)) % 32 + 32) % 32;
            if (rel < 8) m_mask[rel * 512 + int'(wo)] = 1'b1;
            else         err_n = 1'b1;
        end
        if (hit) m_live = 1'b0;
        if (av && rdy) begin
            m_live = 1'b1; m_vdv = avdv; m_vd = avd; m_inst = ai;
            m_cnt = int'(ac); m_mask = '0;
        end
        m_err = err_n;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input logic [4:0] vs, input logic [8:0] off, input logic [2:0] inst);
        cyc(0, 0, 0, 0, 0, 1, vs, off, inst, 0, 0);
    endtask

    task automatic reset_pulse();
        snap_t s;
        @(posedge clock);
        #1;
        alloc_valid = 0; write_valid = 0; retire_valid = 0;
        reset = 1'b0;
        m_live = 0; m_vdv = 0; m_vd = '0; m_inst = '0; m_cnt = 0; m_err = 0; m_mask = '0;
        s.ready = 1'b1; s.live = 1'b0; s.done = 1'b0; s.vdv = 1'b0; s.vd = '0; s.inst = '0;
        s.err = 1'b0; s.chk_mask = 1'b1; s.mask = '0;
        sb.push_back(s);
        #1;
        chk("async_rst_valid", 32'(recordValid), 32'd0);
        chk("async_rst_ready", 32'(alloc_ready), 32'd1);
        chk_mask(record_bits_elementMask, '0);
        @(negedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic       av, avdv, wv, rv;
        logic [4:0] avd, wvs;
        logic [2:0] ai, wi, ri;
        logic [12:0] ac;
        logic [8:0] wo;

        #22 reset = 1'b1;
        idle();

        // Three in-window writes complete a count of three.
        cyc(1, 1, 8, 2, 3, 0, 0, 0, 0, 0, 0);
        wr(8, 0, 2); wr(9, 5, 2); wr(15, 511, 2);
        idle(); idle();

        // Retire and re-allocate together; vd=30 wraps vs=1 to rel 3, vs=6 is out of window.
        cyc(1, 1, 30, 5, 4, 0, 0, 0, 0, 1, 2);
        wr(1, 0, 5); wr(6, 0, 5);
        idle(); idle();

        // Duplicate writes do not count; a distinct second write completes.
        cyc(1, 1, 0, 1, 2, 0, 0, 0, 0, 1, 5);
        wr(0, 7, 1); wr(0, 7, 1); idle();
        wr(0, 8, 1); idle();

        // A write from another instruction is ignored.
        wr(0, 9, 3); idle();

        // Retire hit in ACTIVE with a same-cycle allocation.
        cyc(1, 1, 2, 6, 5, 0, 0, 0, 0, 1, 1);
        wr(2, 1, 6);
        cyc(1, 1, 4, 3, 5, 0, 0, 0, 0, 1, 6);
        idle();

        // Asynchronous reset mid-record.
        wr(4, 0, 3); wr(5, 1, 3);
        reset_pulse();
        idle();

        // No destination: done right after allocation, writes ignored.
        cyc(1, 0, 3, 4, 2, 0, 0, 0, 0, 0, 0);
        wr(3, 0, 4); idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
        idle();

        for (int i = 0; i < 400; i++) begin
            av = 0; avdv = 0; avd = '0; ai = '0; ac = '0;
            wv = 0; wvs = '0; wo = '0; wi = '0; rv = 0; ri = '0;
            if (!m_live || $urandom_range(0, 19) == 0) begin
                av = 1; avdv = ($urandom_range(0, 9) != 0);
                avd = 5'($urandom); ai = 3'($urandom); ac = 13'($urandom_range(1, 8));
            end
            if (m_live && $urandom_range(0, 24) == 0) begin
                rv = 1; ri = ($urandom_range(0, 3) == 0) ? 3'($urandom) : m_inst;
            end
            if ($urandom_range(0, 9) < 7) begin
                wv = 1;
                wvs = m_vd + 5'($urandom_range(0, 9));
                wo = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 3));
                wi = ($urandom_range(0, 9) == 0) ? 3'($urandom) : m_inst;
            end
            cyc(av, avdv, avd, ai, ac, wv, wvs, wo, wi, rv, ri);
        end

        @(posedge clock);
        #1;
        alloc_valid = 0; write_valid = 0; retire_valid = 0;
        @(negedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
